// File: rtl/i2c_cmd_sequencer.sv
// Queued command front-end for the byte-level I2C master: command FIFO in, read-byte FIFO out, sticky errors.
// Optional watchdog on the master handshake: define I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
  parameter int CQ_DEPTH      = 16,
  parameter int RQ_DEPTH      = 8,
  parameter int DVSR_W        = 10,
  parameter int ABORT_ON_NACK = 1,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DVSR_W-1:0]           cfg_dvsr,
  input  logic                        cq_wr,
  input  logic [2:0]                  cq_cmd,
  input  logic [7:0]                  cq_data,
  output logic                        cq_full,
  output logic [$clog2(CQ_DEPTH):0]   cq_level,
  input  logic                        rq_rd,
  output logic [7:0]                  rq_data,
  output logic                        rq_empty,
  output logic                        busy,
  output logic                        nack_err,
  output logic                        ovf_err,
  output logic                        tmo_err,
  input  logic                        err_clr,
  output logic [DVSR_W-1:0]           m_dvsr,
  output logic [2:0]                  m_cmd,
  output logic [7:0]                  m_din,
  output logic                        m_wr_i2c,
  input  logic                        m_ready,
  input  logic                        m_ack,
  input  logic [7:0]                  m_dout
);
  localparam int CAW = $clog2(CQ_DEPTH);
  localparam int RAW = $clog2(RQ_DEPTH);
  localparam logic [2:0] C_WR   = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [2:0] C_STOP = 3'b011;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] data;
  } cq_ent_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE, S_FORCE_STOP
  } state_t;

  state_t state, state_n;

  // ---------------- command FIFO ----------------
  cq_ent_t        cq_mem [CQ_DEPTH];
  cq_ent_t        cq_head;
  logic [CAW:0]   cq_wp, cq_rp;
  logic           cq_empty, cq_push, cq_pop, cq_flush;

  assign cq_empty = (cq_wp == cq_rp);
  assign cq_full  = (cq_wp[CAW] != cq_rp[CAW]) && (cq_wp[CAW-1:0] == cq_rp[CAW-1:0]);
  assign cq_level = cq_wp - cq_rp;
  assign cq_push  = cq_wr & ~cq_full & ~cq_flush;
  assign cq_head  = cq_mem[cq_rp[CAW-1:0]];

  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wp[CAW-1:0]] <= '{cmd: cq_cmd, data: cq_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_wp <= '0;
      cq_rp <= '0;
    end else begin
      if (cq_push) cq_wp <= cq_wp + (CAW+1)'(1);
      // flush drops everything queued; push is already blocked this cycle
      if (cq_flush)    cq_rp <= cq_wp;
      else if (cq_pop) cq_rp <= cq_rp + (CAW+1)'(1);
    end
  end

  // ---------------- read FIFO ----------------
  logic [7:0]     rq_mem [RQ_DEPTH];
  logic [RAW:0]   rq_wp, rq_rp;
  logic           rq_full, rq_push, rq_pop;

  assign rq_empty = (rq_wp == rq_rp);
  assign rq_full  = (rq_wp[RAW] != rq_rp[RAW]) && (rq_wp[RAW-1:0] == rq_rp[RAW-1:0]);
  assign rq_pop   = rq_rd & ~rq_empty;
  assign rq_data  = rq_empty ? 8'h00 : rq_mem[rq_rp[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wp[RAW-1:0]] <= m_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wp <= '0;
      rq_rp <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + (RAW+1)'(1);
      if (rq_pop)  rq_rp <= rq_rp + (RAW+1)'(1);
    end
  end

  // ---------------- sequencing FSM ----------------
  logic ld_head, ld_stop, nack_set, ovf_set;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_wait, tmo_hit;
  assign in_wait = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign tmo_hit = in_wait && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_n  = state;
    cq_pop   = 1'b0;
    cq_flush = 1'b0;
    rq_push  = 1'b0;
    ld_head  = 1'b0;
    ld_stop  = 1'b0;
    nack_set = 1'b0;
    ovf_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cq_empty && m_ready) begin
          state_n = S_ISSUE;
          ld_head = 1'b1;
        end
      end
      S_ISSUE: begin
        cq_pop  = 1'b1;
        state_n = S_WAIT_BUSY;
      end
      S_FORCE_STOP: state_n = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (!m_ready) state_n = S_WAIT_DONE;
      S_WAIT_DONE:  if (m_ready)  state_n = S_COMPLETE;
      S_COMPLETE: begin
        state_n = S_IDLE;
        if (m_cmd == C_RD) begin
          if (rq_full) ovf_set = 1'b1;
          else         rq_push = 1'b1;
        end
        if (m_cmd == C_WR && m_ack) nack_set = 1'b1;
        if (nack_set && ABORT_ON_NACK != 0) begin
          cq_flush = 1'b1;
          ld_stop  = 1'b1;
          state_n  = S_FORCE_STOP;
        end else if (!cq_empty && m_ready) begin
          // chain straight into the next command to keep the gap at two cycles
          ld_head = 1'b1;
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    if (tmo_hit) begin
      state_n  = S_IDLE;
      cq_flush = 1'b1;
      ld_head  = 1'b0;
      ld_stop  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      m_cmd    <= '0;
      m_din    <= '0;
      m_dvsr   <= '0;
      nack_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (ld_head) begin
        m_cmd <= cq_head.cmd;
        m_din <= (cq_head.cmd == C_RD) ? {7'b0, cq_head.data[0]} : cq_head.data;
      end else if (ld_stop) begin
        m_cmd <= C_STOP;
        m_din <= 8'h00;
      end
      if (state == S_IDLE) m_dvsr <= cfg_dvsr;
      nack_err <= nack_set | (nack_err & ~err_clr);
      ovf_err  <= ovf_set  | (ovf_err  & ~err_clr);
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  // counts across the whole WAIT_BUSY/WAIT_DONE window, restarting on each entry to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (in_wait && (state_n == S_WAIT_BUSY || state_n == S_WAIT_DONE))
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      tmo_err <= tmo_hit | (tmo_err & ~err_clr);
    end
  end
`else
  assign tmo_err = 1'b0;
`endif

  assign m_wr_i2c = (state == S_ISSUE) || (state == S_FORCE_STOP);
  assign busy     = (state != S_IDLE) || !cq_empty;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a transaction-level model of the queue, read FIFO and sticky errors.
module tb_i2c_cmd_sequencer;
  localparam int CQD = 16;
  localparam int RQD = 8;
  localparam int DW  = 10;
  localparam int TMO = 64;
  localparam logic [2:0] START = 3'b000, WR = 3'b001, RD = 3'b010, STOP = 3'b011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] cfg_dvsr;
  logic          cq_wr;
  logic [2:0]    cq_cmd;
  logic [7:0]    cq_data;
  logic          cq_full;
  logic [4:0]    cq_level;
  logic          rq_rd;
  logic [7:0]    rq_data;
  logic          rq_empty, busy, nack_err, ovf_err, tmo_err, err_clr;
  logic [DW-1:0] m_dvsr;
  logic [2:0]    m_cmd;
  logic [7:0]    m_din;
  logic          m_wr_i2c, m_ready, m_ack;
  logic [7:0]    m_dout;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.CQ_DEPTH(CQD), .RQ_DEPTH(RQD), .DVSR_W(DW), .ABORT_ON_NACK(1), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_dvsr(cfg_dvsr), .cq_wr(cq_wr), .cq_cmd(cq_cmd), .cq_data(cq_data),
    .cq_full(cq_full), .cq_level(cq_level), .rq_rd(rq_rd), .rq_data(rq_data), .rq_empty(rq_empty),
    .busy(busy), .nack_err(nack_err), .ovf_err(ovf_err), .tmo_err(tmo_err), .err_clr(err_clr),
    .m_dvsr(m_dvsr), .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c), .m_ready(m_ready),
    .m_ack(m_ack), .m_dout(m_dout));

  int nvec = 0;
  int nerr = 0;

  // master-model controls and model state
  logic       hold = 1'b0, stuck = 1'b0, nack_en = 1'b0;
  logic [7:0] nack_byte = 8'h00;
  logic [7:0] rd_src [$];
  logic [10:0] mcq [$];
  logic [7:0]  mrq [$];
  logic [10:0] log_q [$];
  logic e_nack, e_ovf, exp_stop, pend, prev_wr, prev_ready, have_last;
  logic [2:0]  pend_cmd;
  logic [10:0] last_issue;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // slave-side master model: busy for 3 cycles per command, answers from rd_src / nack_byte
  task automatic master();
    logic [2:0] c;
    logic [7:0] d;
    m_ready = 1'b1; m_ack = 1'b0; m_dout = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_ready = 1'b1;
      end else if (m_wr_i2c) begin
        c = m_cmd; d = m_din;
        m_ready = 1'b0;
        while (stuck && rst_n) begin @(posedge clk); #1; end
        for (int i = 0; i < 3 && rst_n; i++) begin @(posedge clk); #1; end
        if (rst_n) begin
          m_ack = (c == WR) && nack_en && (d == nack_byte);
          if (c == RD) m_dout = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
        end
        m_ready = 1'b1;
      end else begin
        m_ready = !hold;
      end
    end
  endtask

  // reference model + per-cycle compare
  task automatic monitor();
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcq.delete(); mrq.delete();
        e_nack = 0; e_ovf = 0; exp_stop = 0; pend = 0;
        prev_wr = 0; prev_ready = 1; have_last = 0;
        continue;
      end
      if (!busy && m_ready) begin
        chk("q_rq_empty", rq_empty, (mrq.size() == 0));
        if (mrq.size() > 0) chk("q_rq_data", rq_data, mrq[0]);
        chk("q_nack_err", nack_err, e_nack);
        chk("q_ovf_err", ovf_err, e_ovf);
      end
      if (hold || (!busy && m_ready)) chk("q_cq_level", cq_level, mcq.size());
      if (cq_wr && mcq.size() < CQD)
        mcq.push_back({cq_cmd, (cq_cmd == RD) ? {7'b0, cq_data[0]} : cq_data});
      if (m_wr_i2c) begin
        chk("strobe_width", prev_wr, 0);
        if (exp_stop)             exp = {STOP, 8'h00};
        else if (mcq.size() > 0)  exp = mcq.pop_front();
        else                      exp = 11'h7FF;
        exp_stop = 0;
        chk("issue", {m_cmd, m_din}, exp);
        log_q.push_back({m_cmd, m_din});
        last_issue = {m_cmd, m_din}; have_last = 1;
        pend = 1; pend_cmd = m_cmd;
      end else if (have_last) begin
        chk("hold_stable", {m_cmd, m_din}, last_issue);
      end
      if (pend && m_ready && !prev_ready) begin
        pend = 0;
        if (pend_cmd == RD) begin
          if (mrq.size() < RQD) mrq.push_back(m_dout);
          else                  e_ovf = 1;
        end
        if (pend_cmd == WR && m_ack) begin
          e_nack = 1; mcq.delete(); exp_stop = 1;
        end
      end
      if (rq_rd && mrq.size() > 0) void'(mrq.pop_front());
      if (err_clr) begin e_nack = 0; e_ovf = 0; end
      prev_wr = m_wr_i2c;
      prev_ready = m_ready;
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] d);
    cq_wr = 1'b1; cq_cmd = c; cq_data = d;
    @(posedge clk); #1;
    cq_wr = 1'b0;
  endtask

  task automatic pop();
    rq_rd = 1'b1;
    @(posedge clk); #1;
    rq_rd = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic wait_idle(input int n, input string nm);
    int i = 0;
    while ((busy || !m_ready) && i < n) begin @(posedge clk); #1; i++; end
    chk(nm, {busy, !m_ready}, 0);
  endtask

  task automatic wait_strobe(input logic [2:0] c, input string nm);
    int i = 0;
    while (!(m_wr_i2c && m_cmd == c) && i < 60) begin @(posedge clk); #1; i++; end
    chk(nm, m_wr_i2c, 1);
  endtask

  initial begin
    int base, n;
    rst_n = 0; cfg_dvsr = 10'h155; cq_wr = 0; cq_cmd = 0; cq_data = 0; rq_rd = 0; err_clr = 0;
    fork
      master();
      monitor();
    join_none
    repeat (3) @(posedge clk); #1;
    chk("rst_rq_empty", rq_empty, 1);
    chk("rst_cq_level", cq_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", m_wr_i2c, 0);
    chk("rst_errs", {nack_err, ovf_err, tmo_err, cq_full}, 0);
    chk("rst_mdvsr", m_dvsr, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("dvsr_latch", m_dvsr, 10'h155);

    // 1: plain write transaction, latency and ordering
    base = log_q.size();
    push(START, 8'h00);
    chk("t1_lat_early", m_wr_i2c, 0);
    chk("t1_busy", busy, 1);
    push(WR, 8'hA0);
    chk("t1_lat_2cyc", m_wr_i2c, 1);
    push(WR, 8'h0B);
    push(STOP, 8'h00);
    wait_idle(400, "t1_idle");
    chk("t1_count", log_q.size() - base, 4);
    chk("t1_din1", log_q[base+1], {WR, 8'hA0});
    chk("t1_din2", log_q[base+2], {WR, 8'h0B});
    chk("t1_stop", log_q[base+3], {STOP, 8'h00});
    chk("t1_errs", {nack_err, ovf_err, busy}, 0);

    // 2: reads land in the read FIFO, RD din carries only the NACK-last flag
    rd_src.push_back(8'h5C); rd_src.push_back(8'h3E);
    base = log_q.size();
    push(START, 8'h00); push(WR, 8'hA1); push(RD, 8'hFE); push(RD, 8'h01); push(STOP, 8'h00);
    wait_idle(400, "t2_idle");
    chk("t2_rd0_din", log_q[base+2], {RD, 8'h00});
    chk("t2_rd1_din", log_q[base+3], {RD, 8'h01});
    chk("t2_nonempty", rq_empty, 0);
    chk("t2_byte0", rq_data, 8'h5C);
    pop();
    chk("t2_byte1", rq_data, 8'h3E);
    pop();
    chk("t2_empty", rq_empty, 1);

    // 3: NACK aborts the queue and forces a single STOP
    nack_en = 1; nack_byte = 8'hA0;
    base = log_q.size();
    push(START, 8'h00); push(WR, 8'hA0); push(WR, 8'h11); push(STOP, 8'h00);
    wait_idle(400, "t3_idle");
    chk("t3_nack", nack_err, 1);
    chk("t3_level", cq_level, 0);
    chk("t3_count", log_q.size() - base, 3);
    chk("t3_forced_stop", log_q[base+2], {STOP, 8'h00});
    n = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i][10:8] == STOP || log_q[i] == {WR, 8'h11}) n++;
    chk("t3_one_stop_no11", n, 1);
    nack_en = 0;
    clr();
    chk("t3_clr", nack_err, 0);

    // 4: command FIFO fills while the master is held, read FIFO overflows
    hold = 1;
    repeat (2) @(posedge clk); #1;
    base = log_q.size();
    push(START, 8'h00);
    for (int i = 0; i < 9; i++) begin push(RD, 8'h00); rd_src.push_back(8'(8'h10 + i)); end
    for (int i = 1; i <= 5; i++) push(WR, 8'(i));
    push(STOP, 8'h00);
    push(WR, 8'hEE);
    chk("t4_full", cq_full, 1);
    chk("t4_level", cq_level, 16);
    hold = 0;
    wait_idle(2000, "t4_idle");
    chk("t4_ovf", ovf_err, 1);
    chk("t4_count", log_q.size() - base, 16);
    chk("t4_last_stop", log_q[log_q.size()-1], {STOP, 8'h00});
    for (int i = 0; i < RQD; i++) begin
      chk("t4_rq", rq_data, 8'(8'h10 + i));
      pop();
    end
    chk("t4_rq_empty", rq_empty, 1);
    clr();
    chk("t4_clr", ovf_err, 0);

    // 5: reset in the middle of a WR
    push(START, 8'h00); push(WR, 8'h55);
    wait_strobe(WR, "t5_wr_seen");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_inflight", busy, 1);
    rst_n = 0; #1;
    chk("t5_rst_wr", m_wr_i2c, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rq", rq_empty, 1);
    chk("t5_rst_lvl", cq_level, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    base = log_q.size();
    push(START, 8'h00); push(STOP, 8'h00);
    wait_idle(400, "t5_idle");
    chk("t5_count", log_q.size() - base, 2);
    chk("t5_start", log_q[base], {START, 8'h00});

`ifdef I2C_SEQ_TIMEOUT_EN
    // 6: watchdog on a master that never returns ready
    stuck = 1;
    push(START, 8'h00);
    wait_strobe(START, "t6_start_seen");
    repeat (64) @(posedge clk); #1;
    chk("t6_pre", {tmo_err, busy}, 2'b01);
    @(posedge clk); #1;
    chk("t6_tmo", {tmo_err, busy}, 2'b10);
    clr();
    chk("t6_clr", tmo_err, 0);
    stuck = 0;
    wait_idle(400, "t6_idle");
`else
    chk("t6_tmo_off", tmo_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
